// File: rtl/instr_fetch_buffer_if.sv
// Fetch-buffer bus bundle: Avalon-style instruction read port, redirect
// input and the decode-side valid/ready head port.
// master: the fetch buffer. slave: memory + decode environment.
interface instr_fetch_buffer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_waitrequest;
    logic [31:0]       mem_readdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_ready;
    logic              instr_valid;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output mem_address, mem_read, instr_valid, instruction, instr_pc,
        input  mem_waitrequest, mem_readdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_address, mem_read, instr_valid, instruction, instr_pc,
        output mem_waitrequest, mem_readdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction prefetch buffer: sequential reads on an Avalon-style port with
// waitrequest, DEPTH-entry (data, pc) FIFO toward decode, redirect flush.
// Optional macro INSTR_FETCH_BYTE_SWAP_EN: byte-reverse read data before the
// FIFO write (little-endian memory feeding a big-endian core).
module instr_fetch_buffer #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC0_0000)
) (
    input logic                 clk,
    input logic                 reset_n,
    instr_fetch_buffer_if.master bus
);
    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              discard_q, discard_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic              accept, push, pop, redirect;
    logic [31:0]       wdata;

    assign redirect = bus.redirect_valid;
    // REQ always has mem_read high, so acceptance is just "no stall".
    assign accept   = (state_q == REQ) && !bus.mem_waitrequest;
    // The response cycle is RESP; stale or redirect-cycle responses are dropped.
    assign push     = (state_q == RESP) && !discard_q && !redirect;
    assign pop      = (count_q != '0) && bus.instr_ready && !redirect;

`ifdef INSTR_FETCH_BYTE_SWAP_EN
    assign wdata = {bus.mem_readdata[7:0],   bus.mem_readdata[15:8],
                    bus.mem_readdata[23:16], bus.mem_readdata[31:24]};
`else
    assign wdata = bus.mem_readdata;
`endif

    // FIFO pointer/occupancy update; redirect empties the buffer outright.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Fetch control: issue only when the post-edge occupancy leaves a free
    // slot, since at issue time nothing else is in flight.
    always_comb begin
        state_d       = state_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        discard_d     = discard_q;
        // A stale (discarded) read must not advance a redirected fetch_pc.
        if (redirect)                 fetch_pc_d = bus.redirect_pc;
        else if (accept && !discard_q) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        else                          fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (count_d < FULL) begin
                    state_d       = REQ;
                    mem_read_d    = 1'b1;
                    mem_address_d = fetch_pc_d;
                end
            end
            REQ: begin
                // Bus rule: a stalled request stays on the bus; mark it stale.
                if (redirect) discard_d = 1'b1;
                if (accept) begin
                    state_d    = RESP;
                    mem_read_d = 1'b0;
                end
            end
            RESP: begin
                discard_d = 1'b0;
                if (count_d < FULL) begin
                    state_d       = REQ;
                    mem_read_d    = 1'b1;
                    mem_address_d = fetch_pc_d;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_address_q <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            discard_q     <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            fetch_pc_q    <= fetch_pc_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage; mem_address_q still holds the accepted address in RESP.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= wdata;
            pc_q[wr_ptr_q]   <= mem_address_q;
        end
    end

    // Credit accounting must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        push |-> (count_q != FULL));

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = mem_address_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instruction = data_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed scenarios plus random traffic,
// checked each cycle against a queue-based model of the instruction stream.
module tb_instr_fetch_buffer;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef INSTR_FETCH_BYTE_SWAP_EN
    localparam logic [31:0] SWAP_EXP = 32'h4433_2211;
`else
    localparam logic [31:0] SWAP_EXP = 32'h1122_3344;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_buffer_if #(.ADDR_W(32)) bus ();

    instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // memory contents: addr^1, with one marker word for the endianness check
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'h1122_3344 : (a ^ 32'h1);
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] d);
`ifdef INSTR_FETCH_BYTE_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // model: expected FIFO contents {pc,data}, plus request/response tracking
    logic [63:0] exp_q[$];
    int          epoch = 0, req_tag = 0, resp_tag = 0;
    bit          resp_pend = 0, prev_rd = 0, prev_acc = 0;
    logic [31:0] resp_addr = '0, prev_addr = '0, exp_addr = RESET_PC;
    int          n_req = 0, n_acc = 0;
    logic        obs_rd, obs_valid;
    logic [31:0] obs_addr, obs_ins, obs_pc;

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input bit wr, input bit rdy, input bit rv, input logic [31:0] rpc);
        bit hold, nreq, acc, psh;
        @(negedge clk);
        bus.mem_waitrequest = wr;
        bus.instr_ready     = rdy;
        bus.redirect_valid  = rv;
        bus.redirect_pc     = rpc;
        bus.mem_readdata    = resp_pend ? memf(resp_addr) : $urandom;
        obs_rd    = bus.mem_read;
        obs_addr  = bus.mem_address;
        obs_valid = bus.instr_valid;
        obs_ins   = bus.instruction;
        obs_pc    = bus.instr_pc;
        chk("valid", 64'(obs_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("instr", 64'(obs_ins), 64'(exp_q[0][31:0]));
            chk("pc", 64'(obs_pc), 64'(exp_q[0][63:32]));
        end
        hold = prev_rd && !prev_acc;
        if (hold) begin
            chk("hold_rd", 64'(obs_rd), 64'd1);
            chk("hold_addr", 64'(obs_addr), 64'(prev_addr));
        end
        nreq = obs_rd && !hold;
        if (nreq) begin
            chk("req_addr", 64'(obs_addr), 64'(exp_addr));
            chk("credit_full", 64'(exp_q.size() >= DEPTH), 64'd0);
            exp_addr = exp_addr + 32'd4;
            req_tag  = epoch;
            n_req++;
        end
        acc = obs_rd && !wr;
        psh = resp_pend && (resp_tag == epoch) && !rv;
        if (rv) begin
            exp_q.delete();
            epoch++;
            exp_addr = rpc;
        end else begin
            if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
            if (psh) exp_q.push_back({resp_addr, sw(memf(resp_addr))});
        end
        if (acc) n_acc++;
        resp_pend = acc;
        resp_tag  = req_tag;
        resp_addr = obs_addr;
        prev_rd   = obs_rd;
        prev_acc  = acc;
        prev_addr = obs_addr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.mem_waitrequest = 1'b0;
        bus.instr_ready     = 1'b0;
        #1;
        chk("rst_rd", 64'(bus.mem_read), 64'd0);
        chk("rst_addr", 64'(bus.mem_address), 64'(RESET_PC));
        chk("rst_valid", 64'(bus.instr_valid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        epoch++;
        exp_addr  = RESET_PC;
        resp_pend = 0;
        prev_rd   = 0;
        prev_acc  = 0;
    endtask

    // wait (bounded) for a request on the bus while stalling it
    task automatic wait_req_stalled();
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1, 1, 0, '0);
            seen = obs_rd;
        end
        if (!seen) chk("timeout_req", 64'd0, 64'd1);
    endtask

    initial begin
        int n0;
        bit hit;
        logic [31:0] r;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.instr_ready     = 1'b0;
        do_reset();

        // fill with decode stalled: exactly DEPTH reads, then the bus goes quiet
        n_req = 0;
        repeat (20) step(0, 0, 0, '0);
        chk("fill_nreq", 64'(n_req), 64'd4);
        chk("fill_idle", 64'(obs_rd), 64'd0);
        chk("head_pc", 64'(obs_pc), 64'(RESET_PC));
        chk("head_ins", 64'(obs_ins), 64'(sw(32'hBFC0_0001)));

        // drain in order, fetch resumes
        repeat (20) step(0, 1, 0, '0);
        chk("resume", 64'(n_req >= 9), 64'd1);

        // five-cycle stall: one acceptance only
        wait_req_stalled();
        n0 = n_acc;
        repeat (4) step(1, 1, 0, '0);
        step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        chk("stall_acc", 64'(n_acc - n0), 64'd1);

        // redirect while a read is stalled
        wait_req_stalled();
        step(1, 1, 1, 32'h0040_0000);
        step(1, 1, 0, '0);
        step(0, 1, 0, '0);
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step(0, 1, 0, '0);
            hit = obs_valid;
        end
        chk("redir_seen", 64'(hit), 64'd1);
        chk("redir_pc", 64'(obs_pc), 64'h0040_0000);

        // redirect coinciding with a pop and a response
        hit = 0;
        for (int k = 0; k < 30 && !hit; k++) begin
            if (exp_q.size() >= 2 && resp_pend) hit = 1;
            else step(0, 0, 0, '0);
        end
        chk("rpr_setup", 64'(hit), 64'd1);
        step(0, 1, 1, 32'h0000_0100);
        step(0, 1, 0, '0);
        chk("flush_valid", 64'(obs_valid), 64'd0);

        // endianness of the stored word
        step(0, 1, 1, 32'h0000_1000);
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step(0, 1, 0, '0);
            hit = obs_valid && (obs_pc == 32'h0000_1000);
        end
        chk("swap_seen", 64'(hit), 64'd1);
        chk("swap", 64'(obs_ins), 64'(SWAP_EXP));

        // PC wrap through zero
        step(0, 1, 1, 32'hFFFF_FFF8);
        hit = 0;
        for (int k = 0; k < 14; k++) begin
            step(0, 1, 0, '0);
            if (obs_valid && obs_pc == 32'h0) hit = 1;
        end
        chk("wrap", 64'(hit), 64'd1);

        // redirect while idle with a full buffer
        repeat (20) step(0, 0, 0, '0);
        chk("idle_rd", 64'(obs_rd), 64'd0);
        step(0, 0, 1, 32'h0000_2000);
        step(0, 0, 0, '0);
        chk("idle_redir_rd", 64'(obs_rd), 64'd1);
        chk("idle_redir_addr", 64'(obs_addr), 64'h0000_2000);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            r = $urandom;
            step(($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 25) == 0,
                 (($urandom % 8) == 0) ? 32'hFFFF_FFF0 : {r[31:2], 2'b00});
        end

        // reset during a response cycle: the response must not surface
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (resp_pend) hit = 1;
            else step(0, 1, 0, '0);
        end
        chk("midrst_setup", 64'(hit), 64'd1);
        do_reset();
        repeat (12) step(0, 1, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Parametrised successor to the single-word memory-to-instruction path.
- Issues instruction reads on the Avalon-style memory port with waitrequest, and prefetches sequential words into a DEPTH-entry FIFO.
- Presents instruction and PC to decode with a valid/ready handshake.
- Supports a branch/jump redirect that flushes the buffer and discards any in-flight read.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 32, address/PC width
RESET_PC, 32'hBFC00000, first fetch address after reset

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  reset, asynchronous, active-low
mem_address  output  ADDR_W  byte address of the instruction read
mem_read  output  1  read request
mem_waitrequest  input  1  memory stall; the request is accepted in a cycle with mem_read=1 and mem_waitrequest=0
mem_readdata  input  32  read data, valid exactly one cycle after acceptance
redirect_valid  input  1  single-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  input  ADDR_W  new fetch address (word aligned)
instr_ready  input  1  decode accepts the head entry
instr_valid  output  1  head entry valid
instruction  output  32  head instruction word
instr_pc  output  ADDR_W  PC of the head instruction

Behaviour:
- Reset (async, reset_n=0):
  - mem_read=0, mem_address=RESET_PC, instr_valid=0, FIFO count=0.
  - State IDLE, fetch_pc=RESET_PC, in-flight=0, discard=0.
- States:
  - IDLE: if count+inflight<DEPTH, assert mem_read with mem_address=fetch_pc next cycle -> REQ.
  - REQ: mem_read=1, mem_address held stable while mem_waitrequest=1. On acceptance: fetch_pc+=4, inflight=1 -> RESP.
  - RESP: mem_readdata captured into the FIFO (data, pc) unless discard=1; inflight cleared. In the same cycle, a new read may be asserted if count+1<DEPTH (stay REQ-capable), else -> IDLE.
- Throughput and latency:
  - Back-to-back reads give one word per 2 cycles without stalls.
  - Latency from acceptance (cycle N) to instr_valid=1 is cycle N+2.
- Credit rule:
  - Never issue a read unless count+inflight<DEPTH.
  - FIFO never overflows; a push into a full FIFO is a design error and must be asserted against in simulation.
- Output side:
  - The head is presented combinationally from FIFO storage.
  - A pop occurs on instr_valid & instr_ready.
  - Push and pop in the same cycle: count unchanged.
  - Empty: instr_valid=0; instruction/instr_pc are don't-care.
- Redirect (redirect_valid=1):
  - Highest priority. FIFO cleared at that edge and a simultaneous pop is ignored.
  - fetch_pc<=redirect_pc; instr_valid=0 the following cycle.
  - If a read is in REQ with waitrequest=1: keep mem_read/mem_address unchanged until accepted (bus rule), set discard=1, and drop the response.
  - If a response arrives in the redirect cycle, drop it.
  - First post-redirect read is issued after the outstanding transaction completes, at redirect_pc.
- Redirect while idle: the next read is issued at redirect_pc the following cycle.
- PC arithmetic: modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 is legal.
- reset_n asserted mid-transaction: all state cleared immediately; the pending response is ignored.

Optional Feature:
- Macro: INSTR_FETCH_BYTE_SWAP_EN.
- Defined: mem_readdata byte-reversed before the FIFO write ({b0,b1,b2,b3}); memory is little-endian and the CPU is big-endian.
- Undefined: data stored unmodified.

Test Plan:
- Reset release, waitrequest=0, memory returns addr^32'h1: first read at 32'hBFC00000; instr_valid at acceptance+2 with instruction=32'hBFC00001, instr_pc=32'hBFC00000; next read at 32'hBFC00004.
- instr_ready=0, DEPTH=4: exactly 4 reads issued and mem_read stays 0. Release ready: 4 pops in order, PCs BFC00000..BFC0000C, then fetch resumes.
- waitrequest high for 5 cycles: mem_address/mem_read stable for all 5 cycles; exactly one capture follows.
- Redirect to 32'h00400000 while a read is stalled by waitrequest: stalled read completes at the old address, its data never appears, and the next instr_pc=32'h00400000.
- Redirect in the same cycle as a pop and a response: FIFO empty next cycle, response dropped, no duplicate instruction.
- With INSTR_FETCH_BYTE_SWAP_EN, readdata 32'h11223344 -> instruction 32'h44332211; without the macro -> 32'h11223344.
